// File: rtl/ndarray_slice_accum.sv
// ndarray_slice_accum: accumulates LEN-entry slices into a DEPTH-entry frame buffer.
// Each slice lands at offset x, and a slice marked last closes the frame.
// The closed frame is held on O until it is consumed.
// Optional feature macro: NDSLICE_BOUNDS_CHECK_EN. When it is defined, a slice whose
// offset would overrun the buffer writes nothing and sets a sticky err flag.
// When it is not defined, such a slice is clipped to the entries that exist.
module ndarray_slice_accum #(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned LEN   = 2,
    parameter int unsigned ROWS  = 3,
    parameter int unsigned WIDTH = 2,
    parameter int unsigned OFFW  = 3
) (
    input  logic                        CLK,
    input  logic                        ASYNCRESETN,
    input  logic [LEN*ROWS*WIDTH-1:0]   I,
    input  logic [OFFW-1:0]             x,
    input  logic                        last,
    input  logic                        I_valid,
    output logic                        I_ready,
    output logic [DEPTH*ROWS*WIDTH-1:0] O,
    output logic                        O_valid,
    input  logic                        O_ready,
    output logic                        err
);

    localparam int unsigned EW = ROWS * WIDTH;

    typedef enum logic {StFill, StHold} state_e;

    state_e                     state_q, state_d;
    logic [DEPTH*EW-1:0]        frame_q, frame_d;
    logic                       accept;
    logic                       consume;
    logic                       wr_en;

    assign O_valid = (state_q == StHold);
    assign I_ready = !O_valid || O_ready;
    assign accept  = I_valid && I_ready;
    assign consume = O_valid && O_ready;
    assign O       = frame_q;

`ifdef NDSLICE_BOUNDS_CHECK_EN
    localparam logic [OFFW:0] MaxOff = (OFFW+1)'(DEPTH - LEN);

    logic oob;
    logic err_q, err_d;

    assign oob   = {1'b0, x} > MaxOff;
    assign wr_en = !oob;
    assign err   = err_q;

    // Sticky flag: any accepted slice with an overrunning offset raises err until reset.
    always_comb begin
        err_d = err_q | (accept & oob);
    end

    // Error flag register.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign wr_en = 1'b1;
    assign err   = 1'b0;
`endif

    // Buffer next state: clear on consume, then overlay the accepted slice.
    // Addresses use one extra bit so x+k never wraps back onto low entries.
    always_comb begin
        logic [OFFW:0] addr;
        addr    = '0;
        frame_d = frame_q;
        if (consume) begin
            frame_d = '0;
        end
        if (accept && wr_en) begin
            for (int k = 0; k < LEN; k++) begin
                addr = {1'b0, x} + (OFFW+1)'(k);
                for (int j = 0; j < DEPTH; j++) begin
                    if (addr == (OFFW+1)'(j)) begin
                        frame_d[j*EW +: EW] = I[k*EW +: EW];
                    end
                end
            end
        end
    end

    // FSM next state: an accepted slice decides FILL/HOLD by last; a bare consume returns to FILL.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = last ? StHold : StFill;
        end else if (consume) begin
            state_d = StFill;
        end
    end

    // State and buffer registers.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= StFill;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: doc/ndarray_slice_accum.md
NDARRAY_SLICE_ACCUM -- requirements
Module: ndarray_slice_accum

Interface
REQ-001 Parameter DEPTH, 6, number of entries in the frame buffer (outer dimension).
REQ-002 Parameter LEN, 2, number of entries carried by one input slice; 1 <= LEN <= DEPTH.
REQ-003 Parameter ROWS, 3, rows per entry.
REQ-004 Parameter WIDTH, 2, bits per row.
REQ-005 Parameter OFFW, 3, offset width; OFFW >= clog2(DEPTH).
REQ-006 CLK  input  1  clock; all state updates on rising edge.
REQ-007 ASYNCRESETN  input  1  reset, asynchronous, active-low.
REQ-008 I  input  LEN*ROWS*WIDTH  slice data; entry k, row r occupies bits [(k*ROWS+r)*WIDTH +: WIDTH].
REQ-009 x  input  OFFW  destination offset of slice entry 0 in the buffer.
REQ-010 last  input  1  marks the final slice of a frame.
REQ-011 I_valid  input  1  slice valid.
REQ-012 I_ready  output  1  slice accepted when I_valid && I_ready.
REQ-013 O  output  DEPTH*ROWS*WIDTH  frame buffer contents, same packing as I with DEPTH entries.
REQ-014 O_valid  output  1  completed frame presented on O.
REQ-015 O_ready  input  1  frame consumed when O_valid && O_ready.
REQ-016 err  output  1  sticky out-of-range-offset flag.

Function
REQ-017 Two states: FILL (O_valid=0) and HOLD (O_valid=1).
REQ-018 I_ready SHALL equal !O_valid || O_ready (combinational).
REQ-019 On accepted slice, for each k in 0..LEN-1 with x+k < DEPTH, buffer entry x+k SHALL load I entry k at the next edge; all other entries keep their value.
REQ-020 Address arithmetic x+k SHALL be computed at OFFW+1 bits or wider; no wrap-around to low entries.
REQ-021 Accepted slice with last=1 SHALL move FILL->HOLD; O_valid rises the cycle after the edge.
REQ-022 Accepted slice with last=0 SHALL remain/return in FILL.
REQ-023 In HOLD, O and O_valid SHALL stay constant until O_valid && O_ready.
REQ-024 On O_valid && O_ready without accepted slice: buffer SHALL clear to zero, state -> FILL.
REQ-025 On O_valid && O_ready with accepted slice in the same cycle: buffer SHALL clear to zero then apply the slice write (written entries take I, all others zero); next state HOLD if last=1, else FILL.
REQ-026 Overlapping writes within a frame: latest slice wins per entry.
REQ-027 Entries never written in a frame SHALL read zero.
REQ-028 O SHALL be driven directly from registers (no combinational path from I).

Reset
REQ-029 ASYNCRESETN low SHALL immediately force buffer to all zeros, state FILL, O_valid=0, err=0, regardless of CLK.
REQ-030 Reset mid-frame SHALL discard partially written frame; first accepted slice after release starts a new frame.

Configuration
REQ-031 Macro NDSLICE_BOUNDS_CHECK_EN.
REQ-032 Defined: accepted slice with x > DEPTH-LEN SHALL write no entries, SHALL set err (sticky until reset), and last still advances state.
REQ-033 Undefined: such slice SHALL write only in-range entries (clipped), err tied 0.

Verification
REQ-034 Defaults; slice I={e1,e0}, x=1, last=1 -> after one edge O_valid=1, entries1=e0, 2=e1, others 0.
REQ-035 Slices x=0 last=0, then x=4 last=1 -> O entries 0,1,4,5 loaded, 2,3 zero; O_valid only after second slice.
REQ-036 HOLD with O_ready=0 and I_valid=1 -> I_ready=0, O unchanged for 5 cycles; then O_ready=1 with slice x=2 last=1 -> next O has only entries 2,3 nonzero, O_valid stays 1.
REQ-037 x=5, LEN=2: with macro -> no entry changes, err=1 persists; without macro -> entry5=e0 only, err=0.
REQ-038 ASYNCRESETN pulsed low between clock edges mid-frame -> O=0, O_valid=0, err=0 immediately; next x=3 last=1 frame shows only entries 3,4.
REQ-039 Sweep x=0..7 with random data, DEPTH=6 and DEPTH=8/LEN=3 -> buffer matches reference model every cycle.
